// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: F-stage PC, single-outstanding imem handshake and the F/D register.
// Redirects take effect in any state; a word already in flight after a redirect is dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_stall,
    input  logic        d_stall,
    input  logic        d_flush,
    input  logic        e_pc_src,
    input  logic [31:0] e_pc_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        d_valid,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc_plus4
);

    // state | meaning
    // ISSUE | no request outstanding; present f_pc to memory
    // WAIT  | one request outstanding for f_pc
    // HOLD  | response arrived during a D stall; word parked in buf_q
    // DROP  | redirected while a request was outstanding; discard its response
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_pc_plus4_q, d_pc_plus4_d;

    logic [31:0] f_pc_plus4;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_word;
    logic [31:0] req_addr;
    logic        fetch_done;
    logic        consume;
    logic        req_valid;
    logic        req_fire;

    always_comb begin
        f_pc_plus4  = f_pc_q + 32'd4;
        redirect_pc = e_pc_target & 32'hFFFF_FFFC;
        fetch_done  = (state_q == WAIT && imem_rsp_valid) || state_q == HOLD;
        fetch_word  = (state_q == HOLD) ? buf_q : imem_rsp_data;
        consume     = fetch_done && !d_stall && !e_pc_src;

        // In WAIT the next request overlaps the current response for back-to-back fetch.
        req_valid = 1'b0;
        req_addr  = f_pc_q;
        case (state_q)
            ISSUE: req_valid = !f_stall && !e_pc_src;
            WAIT: begin
                if (consume) begin
                    req_valid = !f_stall;
                    req_addr  = f_pc_plus4;
                end
            end
            default: ;
        endcase
        req_fire = req_valid && imem_req_ready;

        state_d = state_q;
        buf_d   = buf_q;
        if (e_pc_src)
            f_pc_d = redirect_pc;
        else if (consume)
            f_pc_d = f_pc_plus4;
        else
            f_pc_d = f_pc_q;

        case (state_q)
            ISSUE: begin
                if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                if (consume) begin
                    state_d = req_fire ? WAIT : ISSUE;
                end else if (imem_rsp_valid && d_stall && !e_pc_src) begin
                    state_d = HOLD;
                    buf_d   = imem_rsp_data;
                end else if (imem_rsp_valid && e_pc_src) begin
                    state_d = ISSUE;
                end else if (e_pc_src) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (consume || e_pc_src) state_d = ISSUE;
            end
            DROP: begin
                if (imem_rsp_valid) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase

        d_valid_d    = d_valid_q;
        d_instr_d    = d_instr_q;
        d_pc_d       = d_pc_q;
        d_pc_plus4_d = d_pc_plus4_q;
        if (d_flush) begin
            d_valid_d = 1'b0;
            d_instr_d = NOP_INSTR;
        end else if (d_stall) begin
            d_valid_d = d_valid_q;
        end else if (consume) begin
            d_valid_d    = 1'b1;
            d_instr_d    = fetch_word;
            d_pc_d       = f_pc_q;
            d_pc_plus4_d = f_pc_plus4;
        end else begin
            d_valid_d = 1'b0;
            d_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ISSUE;
            f_pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            buf_q        <= '0;
            d_valid_q    <= 1'b0;
            d_instr_q    <= NOP_INSTR;
            d_pc_q       <= '0;
            d_pc_plus4_q <= '0;
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            buf_q        <= buf_d;
            d_valid_q    <= d_valid_d;
            d_instr_q    <= d_instr_d;
            d_pc_q       <= d_pc_d;
            d_pc_plus4_q <= d_pc_plus4_d;
        end
    end

    // Request valid is gated by reset so nothing is presented while rst_n is low.
    assign imem_req_valid = req_valid && rst_n;
    assign imem_req_addr  = req_addr & 32'hFFFF_FFFC;
    assign d_valid        = d_valid_q;
    assign d_instr        = d_instr_q;
    assign d_pc           = d_pc_q;
    assign d_pc_plus4     = d_pc_plus4_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the F-stage PC, the instruction-memory request/response handshake and the F/D pipeline register.
- Directly consumes the hazard unit's f_stall, d_stall and d_flush, plus the E-stage redirect (e_pc_src, e_pc_target).
- Produces the D-stage instruction and PC. From these the decoder derives d_rs1/d_rs2 for the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0), so rs1=rs2=0 and no false hazards.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_stall  in  1  hold F-stage PC; no new request issued
- d_stall  in  1  hold F/D register
- d_flush  in  1  load bubble into F/D register
- e_pc_src  in  1  E-stage redirect (taken branch/jump)
- e_pc_target  in  32  redirect PC
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, one per accepted request, in order
- imem_rsp_data  in  32  fetched instruction
- d_valid  out  1  F/D holds a real instruction
- d_instr  out  32  instruction to decode
- d_pc  out  32  PC of d_instr
- d_pc_plus4  out  32  d_pc+4

Behaviour:
- Reset (async assert, sync release):
  - f_pc=RESET_PC, state=ISSUE.
  - d_valid=0, d_instr=NOP_INSTR, d_pc=0, d_pc_plus4=0, hold buffer=0.
  - imem_req_valid=0 while rst_n low.
- Single outstanding request at most. States are ISSUE, WAIT, HOLD, DROP.
- fetch_done = (WAIT & imem_rsp_valid) | HOLD. The fetched word is the buffer in HOLD, otherwise imem_rsp_data.
- consume = fetch_done & !d_stall & !e_pc_src.
- ISSUE:
  - imem_req_valid = !f_stall & !e_pc_src, with addr=f_pc.
  - Handshake (valid&ready) goes to WAIT. Otherwise stay.
  - imem_rsp_valid is ignored in this state.
- WAIT:
  - consume: F/D loads {1, word, f_pc, f_pc+4} and f_pc<=f_pc+4. In the same cycle, imem_req_valid=!f_stall with addr=f_pc+4. If accepted, stay WAIT; else go to ISSUE. This gives 1 instr/cycle with zero-wait memory.
  - rsp & d_stall & !e_pc_src: capture the word into the buffer and go to HOLD.
  - !rsp & e_pc_src: go to DROP.
  - rsp & e_pc_src: discard the word and go to ISSUE.
- HOLD:
  - imem_req_valid=0.
  - consume: load F/D from the buffer, advance f_pc, go to ISSUE.
  - e_pc_src: discard the buffer, go to ISSUE.
- DROP:
  - imem_req_valid=0.
  - On imem_rsp_valid, discard the data and go to ISSUE. The PC was already redirected.
- Redirect: e_pc_src sets f_pc<=e_pc_target in any state. It has priority over f_stall and over consume.
- F/D register, in priority order:
  1. d_flush: load bubble {0, NOP_INSTR, d_pc and d_pc_plus4 unchanged}. Flush wins over d_stall.
  2. d_stall: hold.
  3. consume: load the fetched instruction.
  4. Otherwise: load bubble (memory latency inserts NOPs).
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- imem_req_addr[1:0] is always 0. e_pc_target[1:0] is forced to 0.
- Reset mid-request: state returns to ISSUE and any later stale response is ignored. The memory is reset by the same rst_n.

Test Plan:
- Zero-wait memory (ready=1, rsp next cycle), RESET_PC=0 -> d_pc sequence 0,4,8,C on consecutive cycles after the first fill, d_valid=1 each cycle.
- Memory latency 3 cycles -> each instruction is preceded by 2 bubbles: d_valid=0 and d_instr=32'h0000_0013.
- Response arrives while d_stall=f_stall=1 for 2 cycles -> word held in HOLD; d_pc/d_instr unchanged during the stall; the held word appears in the cycle after the stall drops; no duplicate and no lost fetch.
- e_pc_src=1, target=32'h0000_0100, while WAIT with no response -> d_flush bubble; the late response for the old PC is discarded; the next request addr is 0x100; d_pc=0x100 on the first valid instruction.
- Redirect in the same cycle as imem_rsp_valid and d_stall=1 -> word discarded, f_pc=target, F/D flushed (flush beats stall).
- Assert rst_n=0 asynchronously while WAIT -> outputs take reset values immediately; after release the first request addr=RESET_PC.
